// File: rtl/sound_pwm_out.sv
// PWM audio output stage: one N-bit sample per 2^N-cycle frame, with a
// per-frame linear fade-out once enable_i drops.
module sound_pwm_out #(
   parameter int N         = 8,
   parameter int FADE_STEP = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sample_i,
   input  logic         enable_i,
   output logic         pwm_o,
   output logic         frame_o,
   output logic         busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FADE
   } state_t;

   localparam logic [N-1:0] CNT_MAX = '1;
   localparam logic [N:0]   STEP    = (N+1)'(FADE_STEP);

   state_t       state, state_nxt;
   logic [N-1:0] cnt, cnt_nxt;
   logic [N-1:0] duty, duty_nxt;
   logic         frame_end;
   logic         above_step;
   logic [N-1:0] duty_faded;

   assign frame_end  = (cnt == CNT_MAX);
   // Compare one bit wider so a step larger than any duty never wraps.
   assign above_step = ({1'b0, duty} > STEP);
   assign duty_faded = above_step ? (duty - STEP[N-1:0]) : '0;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      duty_nxt  = duty;
      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            duty_nxt = '0;
            if (enable_i) begin
               state_nxt = RUN;
               duty_nxt  = sample_i;
            end
         end
         RUN, FADE: begin
            cnt_nxt = cnt + N'(1);
            if (frame_end) begin
               if (enable_i) begin
                  state_nxt = RUN;
                  duty_nxt  = sample_i;
               end else if (state == RUN) begin
                  state_nxt = FADE;
                  duty_nxt  = duty_faded;
               end else if (!above_step) begin
                  state_nxt = IDLE;
                  duty_nxt  = '0;
                  cnt_nxt   = '0;
               end else begin
                  duty_nxt  = duty_faded;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            duty_nxt  = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         duty  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         duty  <= duty_nxt;
      end
   end

   // Outputs decode straight from registers, so reset clears them without a clock.
   assign busy_o  = (state != IDLE);
   assign pwm_o   = busy_o && (cnt < duty);
   assign frame_o = busy_o && (cnt == '0);

endmodule

// File: tb/tb_sound_pwm_out.sv
// Self-checking bench for sound_pwm_out: frame-level reference model with a
// per-cycle compare, directed frame scenarios, then randomized traffic.
module tb_sound_pwm_out;

   localparam int FRAME = 256;
   localparam int STEP  = 16;

   logic       clk;
   logic       rst;
   logic [7:0] sample_i;
   logic       enable_i;
   logic       pwm_o;
   logic       frame_o;
   logic       busy_o;

   int tests = 0;
   int fails = 0;

   sound_pwm_out #(.N(8), .FADE_STEP(STEP)) dut (
      .clk      (clk),
      .rst      (rst),
      .sample_i (sample_i),
      .enable_i (enable_i),
      .pwm_o    (pwm_o),
      .frame_o  (frame_o),
      .busy_o   (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: is a frame playing, is it a fade frame, position in frame, duty of frame.
   bit m_active = 0;
   bit m_fading = 0;
   int m_pos    = 0;
   int m_duty   = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 0;
         m_fading <= 0;
         m_pos    <= 0;
         m_duty   <= 0;
      end else if (!m_active) begin
         if (enable_i) begin
            m_active <= 1;
            m_fading <= 0;
            m_pos    <= 0;
            m_duty   <= int'(sample_i);
         end
      end else if (m_pos == FRAME - 1) begin
         m_pos <= 0;
         if (enable_i) begin
            m_fading <= 0;
            m_duty   <= int'(sample_i);
         end else if (m_fading && m_duty <= STEP) begin
            m_active <= 0;
            m_duty   <= 0;
         end else begin
            m_fading <= 1;
            m_duty   <= (m_duty > STEP) ? m_duty - STEP : 0;
         end
      end else begin
         m_pos <= m_pos + 1;
      end
   end

   always @(negedge clk) begin
      int exp_vec;
      exp_vec = {29'd0, (m_active && m_pos < m_duty), (m_active && m_pos == 0), m_active};
      check("cycle_outputs{pwm,frame,busy}", int'({pwm_o, frame_o, busy_o}), exp_vec);
   end

   // Starting on the frame_o cycle, count high pwm cycles over one frame and
   // optionally change inputs once at offset chg_at.
   task automatic measure_frame(input int chg_at, input logic [7:0] chg_sample,
                                input logic chg_en, output int highs, output logic last_bit);
      highs    = 0;
      last_bit = 1'b0;
      check("frame_start", int'(frame_o), 1);
      for (int i = 0; i < FRAME; i++) begin
         highs += int'(pwm_o);
         if (i == FRAME - 1) last_bit = pwm_o;
         if (i == chg_at) begin
            sample_i = chg_sample;
            enable_i = chg_en;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int   h;
      logic lb;
      rst      = 1'b1;
      enable_i = 1'b0;
      sample_i = 8'd0;
      #12;
      check("reset_busy", int'(busy_o), 0);
      check("reset_pwm", int'(pwm_o), 0);
      check("reset_frame", int'(frame_o), 0);

      // Start-up at sample 64.
      @(negedge clk);
      rst      = 1'b0;
      enable_i = 1'b1;
      sample_i = 8'd64;
      check("idle_busy", int'(busy_o), 0);
      @(negedge clk);
      check("start_busy", int'(busy_o), 1);
      check("start_frame", int'(frame_o), 1);
      measure_frame(-1, 8'd64, 1'b1, h, lb);
      check("highs_64_a", h, 64);
      measure_frame(0, 8'd200, 1'b1, h, lb);
      check("highs_64_b", h, 64);

      // Mid-frame sample change takes effect only next frame.
      measure_frame(50, 8'd10, 1'b1, h, lb);
      check("highs_200_hold", h, 200);
      measure_frame(0, 8'd0, 1'b1, h, lb);
      check("highs_10", h, 10);

      // Zero then full-scale in consecutive frames.
      measure_frame(0, 8'd255, 1'b1, h, lb);
      check("highs_0", h, 0);
      measure_frame(0, 8'd40, 1'b1, h, lb);
      check("highs_255", h, 255);
      check("last_low_255", int'(lb), 0);

      // Fade from 40: 24, 8, then idle.
      measure_frame(100, 8'd40, 1'b0, h, lb);
      check("highs_40", h, 40);
      measure_frame(-1, 8'd40, 1'b0, h, lb);
      check("fade_24", h, 24);
      measure_frame(-1, 8'd40, 1'b0, h, lb);
      check("fade_8", h, 8);
      check("fade_idle_busy", int'(busy_o), 0);
      check("fade_idle_pwm", int'(pwm_o), 0);

      // Fade at duty 100 rescued by enable with sample 255.
      enable_i = 1'b1;
      sample_i = 8'd116;
      @(negedge clk);
      measure_frame(0, 8'd116, 1'b0, h, lb);
      check("highs_116", h, 116);
      measure_frame(0, 8'd255, 1'b1, h, lb);
      check("fade_100", h, 100);
      measure_frame(-1, 8'd255, 1'b1, h, lb);
      check("rescue_255", h, 255);
      check("rescue_last_low", int'(lb), 0);

      // Asynchronous reset at cnt=130.
      repeat (130) @(negedge clk);
      check("pre_reset_pwm", int'(pwm_o), 1);
      #1 rst = 1'b1;
      #1;
      check("async_pwm", int'(pwm_o), 0);
      check("async_busy", int'(busy_o), 0);
      check("async_frame", int'(frame_o), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("restart_frame", int'(frame_o), 1);
      check("restart_busy", int'(busy_o), 1);

      // Randomized traffic against the model.
      for (int c = 0; c < 30000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 1499) == 0) enable_i = ~enable_i;
         if ($urandom_range(0, 3) == 0) sample_i = 8'($urandom_range(0, 20));
         else sample_i = 8'($urandom);
         if ($urandom_range(0, 4999) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sound_pwm_out.md
SOUND_PWM_OUT -- requirements
Module: sound_pwm_out

Interface
REQ-001 Parameter N, default 8, sample width in bits; PWM frame length is 2^N clock cycles.
REQ-002 Parameter FADE_STEP, default 16, duty decrement applied per frame while fading out.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 sample_i  input  N  unsigned audio sample (the sound generator's soundOut), sampled only at defined capture points.
REQ-006 enable_i  input  1  level; high requests audio output, low requests fade-out.
REQ-007 pwm_o  output  1  PWM audio pin to speaker/filter.
REQ-008 frame_o  output  1  one-cycle pulse marking the first cycle of each active frame.
REQ-009 busy_o  output  1  high whenever the block is not IDLE.

Function
REQ-010 The block SHALL hold state (IDLE, RUN, FADE), an N-bit frame counter cnt, and an N-bit duty register duty.
REQ-011 pwm_o SHALL be 1 iff state is RUN or FADE and cnt < duty (unsigned); 0 in IDLE.
REQ-012 frame_o SHALL be 1 iff state is RUN or FADE and cnt == 0.
REQ-013 busy_o SHALL be 1 iff state is RUN or FADE.
REQ-014 In IDLE, cnt and duty SHALL hold 0.
REQ-015 IDLE with enable_i=1 at an edge: next state RUN, cnt=0, duty=sample_i captured at that edge (latency one cycle to first frame_o).
REQ-016 In RUN/FADE, cnt SHALL increment by 1 each cycle, wrapping 2^N-1 -> 0; "frame end" = cycle with cnt == 2^N-1.
REQ-017 duty SHALL change only at frame end (or on IDLE->RUN entry); sample_i changes mid-frame SHALL NOT affect pwm_o until the next frame.
REQ-018 RUN, frame end, enable_i=1: stay RUN, duty=sample_i.
REQ-019 RUN, frame end, enable_i=0: go FADE, duty=max(duty-FADE_STEP, 0) saturating.
REQ-020 FADE, frame end, enable_i=1: go RUN, duty=sample_i (enable wins over fade).
REQ-021 FADE, frame end, enable_i=0, duty <= FADE_STEP: go IDLE, duty=0, cnt=0.
REQ-022 FADE, frame end, enable_i=0, duty > FADE_STEP: stay FADE, duty=duty-FADE_STEP.
REQ-023 enable_i changes away from frame end SHALL have no effect in RUN/FADE (changes only at frame boundary).
REQ-024 duty=0 SHALL yield pwm_o constantly 0 for the frame; duty=2^N-1 SHALL yield 2^N-1 high cycles then 1 low cycle.
REQ-025 Subtraction SHALL be done without underflow wrap (no duty value larger than its prior value in FADE).

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, cnt=0, duty=0, so pwm_o=0, frame_o=0, busy_o=0, regardless of clk.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; after release the block restarts only per REQ-015.

Verification
REQ-028 Reset, enable_i=1, sample_i=64 -> busy_o rises next cycle, frame_o pulses every 256 cycles, pwm_o high exactly 64 cycles per frame starting at frame_o.
REQ-029 RUN with sample_i=200, change sample_i to 10 at cnt=50 -> current frame keeps 200 high cycles; next frame 10 high cycles.
REQ-030 RUN at duty=40, drop enable_i -> frames with 24, 8 high cycles, then IDLE (busy_o=0, pwm_o=0) at end of the 8-cycle frame.
REQ-031 FADE at duty=100, raise enable_i with sample_i=255 -> at next frame end state RUN, frame shows 255 high, 1 low.
REQ-032 sample_i=0 then 255 in consecutive frames -> 0 high cycles, then 255 high cycles; no wrap/glitch at boundary.
REQ-033 Assert rst at cnt=130 in RUN -> pwm_o, busy_o, frame_o go 0 without a clock edge; after release with enable_i=1, first frame_o one cycle later.
